// File: rtl/sd_stream_demux_pkg.sv
// Shared types and defaults for the SD-card stream demultiplexer.
package stream_pkg;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      VIDEO = 2'd1,
      AUDIO = 2'd2
   } state_t;

   localparam logic [7:0] HEADER = 8'hFF;

   localparam int VIDEO_BYTES_DEF    = 2400;
   localparam int AUDIO_BYTES_DEF    = 128;
   localparam int TIMEOUT_CYCLES_DEF = 4096;

   // Address width covers the larger of the two payload sections.
   function automatic int addr_width(input int video_bytes, input int audio_bytes);
      if (video_bytes > audio_bytes) begin
         return $clog2(video_bytes);
      end else begin
         return $clog2(audio_bytes);
      end
   endfunction

endpackage

// File: rtl/sd_stream_demux_if.sv
// Buffer-write side of the stream demux: payload byte, address, strobes and status.
interface sd_stream_demux_if #(
   parameter int ADDR_W = 12
);
   logic [7:0]        wr_data;
   logic [ADDR_W-1:0] wr_addr;
   logic              write_video;
   logic              write_audio;
   logic              in_packet;
   logic              frame_done;
   logic              err;

   modport master (
      output wr_data, wr_addr, write_video, write_audio, in_packet, frame_done, err
   );

   modport slave (
      input wr_data, wr_addr, write_video, write_audio, in_packet, frame_done, err
   );
endinterface

// File: rtl/sd_stream_demux_spi_bit_sampler.sv
// Brings SPI_clk/MISO into the system clock domain and flags each SPI_clk rising edge.
module spi_bit_sampler (
   input  logic clk,
   input  logic rst_n,
   input  logic spi_clk,
   input  logic miso,
   output logic bit_valid,
   output logic bit_data
);

   logic clk_meta_r;
   logic clk_sync_r;
   logic clk_prev_r;
   logic miso_meta_r;
   logic miso_sync_r;

   // Two-flop synchronisers plus one history flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_meta_r  <= 1'b0;
         clk_sync_r  <= 1'b0;
         clk_prev_r  <= 1'b0;
         miso_meta_r <= 1'b0;
         miso_sync_r <= 1'b0;
      end else begin
         clk_meta_r  <= spi_clk;
         clk_sync_r  <= clk_meta_r;
         clk_prev_r  <= clk_sync_r;
         miso_meta_r <= miso;
         miso_sync_r <= miso_meta_r;
      end
   end

   // MISO comes from the same synchroniser depth as the clock it is qualified by.
   assign bit_valid = clk_sync_r & ~clk_prev_r;
   assign bit_data  = miso_sync_r;

endmodule

// File: rtl/sd_stream_demux.sv
// SD stream demux: hunts for the 0xFF header and splits the payload into video then audio writes.
// Optional stall timeout abort is compiled in with SD_STREAM_TIMEOUT_EN.
module sd_stream_demux
   import stream_pkg::*;
#(
   parameter int VIDEO_BYTES = VIDEO_BYTES_DEF,
   parameter int AUDIO_BYTES = AUDIO_BYTES_DEF
`ifdef SD_STREAM_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
   input  logic               CLK_40,
   input  logic               reset,
   input  logic               en,
   input  logic               SPI_clk,
   input  logic               MISO,
   sd_stream_demux_if.master  bus
);

   localparam int ADDR_W = addr_width(VIDEO_BYTES, AUDIO_BYTES);
   localparam logic [ADDR_W-1:0] VIDEO_LAST = ADDR_W'(VIDEO_BYTES - 1);
   localparam logic [ADDR_W-1:0] AUDIO_LAST = ADDR_W'(AUDIO_BYTES - 1);

   logic              bit_valid_s;
   logic              bit_data_s;
   logic [7:0]        sh_next_s;
   logic              tmo_hit_s;
   logic              abort_s;

   state_t            state_r;
   logic [7:0]        sh_r;
   logic [2:0]        bit_cnt_r;
   logic [ADDR_W-1:0] byte_cnt_r;
   logic              byte_done_r;
   logic [7:0]        wr_data_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic              write_video_r;
   logic              write_audio_r;
   logic              in_packet_r;
   logic              frame_done_r;

   spi_bit_sampler u_sampler (
      .clk       (CLK_40),
      .rst_n     (reset),
      .spi_clk   (SPI_clk),
      .miso      (MISO),
      .bit_valid (bit_valid_s),
      .bit_data  (bit_data_s)
   );

   assign sh_next_s = {sh_r[6:0], bit_data_s};

`ifdef SD_STREAM_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt_r;
   logic             err_r;

   assign tmo_hit_s = (state_r != HUNT) && !bit_valid_s &&
                      (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

   // Stall counter: cycles in a packet since the last SPI bit
   always_ff @(posedge CLK_40 or negedge reset) begin
      if (!reset) begin
         tmo_cnt_r <= '0;
         err_r     <= 1'b0;
      end else begin
         err_r <= tmo_hit_s;
         if ((state_r == HUNT) || bit_valid_s || tmo_hit_s || !en) begin
            tmo_cnt_r <= '0;
         end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
         end
      end
   end

   assign bus.err = err_r;
`else
   assign tmo_hit_s = 1'b0;
   assign bus.err   = 1'b0;
`endif

   assign abort_s = !en || tmo_hit_s;

   // Packet FSM: header hunt, byte assembly and buffer write strobes
   always_ff @(posedge CLK_40 or negedge reset) begin
      if (!reset) begin
         state_r       <= HUNT;
         sh_r          <= 8'h00;
         bit_cnt_r     <= 3'd0;
         byte_cnt_r    <= '0;
         byte_done_r   <= 1'b0;
         wr_data_r     <= 8'h00;
         wr_addr_r     <= '0;
         write_video_r <= 1'b0;
         write_audio_r <= 1'b0;
         in_packet_r   <= 1'b0;
         frame_done_r  <= 1'b0;
      end else begin
         write_video_r <= 1'b0;
         write_audio_r <= 1'b0;
         frame_done_r  <= 1'b0;
         byte_done_r   <= 1'b0;
         case (state_r)
            HUNT: begin
               in_packet_r <= 1'b0;
               bit_cnt_r   <= 3'd0;
               byte_cnt_r  <= '0;
               if (en && bit_valid_s) begin
                  sh_r <= sh_next_s;
                  if (sh_next_s == HEADER) begin
                     state_r     <= VIDEO;
                     in_packet_r <= 1'b1;
                  end
               end
            end
            VIDEO, AUDIO: begin
               // Abort wins over a byte completing or being written this cycle.
               if (abort_s) begin
                  state_r     <= HUNT;
                  in_packet_r <= 1'b0;
                  sh_r        <= 8'h00;
                  bit_cnt_r   <= 3'd0;
                  byte_cnt_r  <= '0;
               end else begin
                  if (bit_valid_s) begin
                     sh_r        <= sh_next_s;
                     bit_cnt_r   <= bit_cnt_r + 3'd1;
                     byte_done_r <= (bit_cnt_r == 3'd7);
                  end
                  if (byte_done_r) begin
                     wr_data_r <= sh_r;
                     wr_addr_r <= byte_cnt_r;
                     if (state_r == VIDEO) begin
                        write_video_r <= 1'b1;
                        if (byte_cnt_r == VIDEO_LAST) begin
                           state_r    <= AUDIO;
                           byte_cnt_r <= '0;
                        end else begin
                           byte_cnt_r <= byte_cnt_r + ADDR_W'(1);
                        end
                     end else begin
                        write_audio_r <= 1'b1;
                        if (byte_cnt_r == AUDIO_LAST) begin
                           // Clearing sh keeps trailing ones from faking a new header.
                           frame_done_r <= 1'b1;
                           state_r      <= HUNT;
                           sh_r         <= 8'h00;
                           bit_cnt_r    <= 3'd0;
                           byte_cnt_r   <= '0;
                        end else begin
                           byte_cnt_r <= byte_cnt_r + ADDR_W'(1);
                        end
                     end
                  end
               end
            end
            default: begin
               state_r     <= HUNT;
               in_packet_r <= 1'b0;
               sh_r        <= 8'h00;
            end
         endcase
      end
   end

   assign bus.wr_data     = wr_data_r;
   assign bus.wr_addr     = wr_addr_r;
   assign bus.write_video = write_video_r;
   assign bus.write_audio = write_audio_r;
   assign bus.in_packet   = in_packet_r;
   assign bus.frame_done  = frame_done_r;

endmodule

// File: tb/tb_sd_stream_demux.sv
// Self-checking bench for sd_stream_demux with a stream-level reference model (VIDEO_BYTES=4, AUDIO_BYTES=2).
`timescale 1ns/100ps
module tb_sd_stream_demux;

   localparam int VB = 4;
   localparam int AB = 2;
   localparam int AW = 2;

   logic CLK_40  = 1'b0;
   logic reset   = 1'b0;
   logic en      = 1'b0;
   logic SPI_clk = 1'b0;
   logic MISO    = 1'b0;

   sd_stream_demux_if #(.ADDR_W(AW)) bus ();

   sd_stream_demux #(
      .VIDEO_BYTES (VB),
      .AUDIO_BYTES (AB)
`ifdef SD_STREAM_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (100)
`endif
   ) dut (
      .CLK_40  (CLK_40),
      .reset   (reset),
      .en      (en),
      .SPI_clk (SPI_clk),
      .MISO    (MISO),
      .bus     (bus)
   );

   always #12.5 CLK_40 = ~CLK_40;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int edge_cyc = 0;
   int vad[$], vda[$], aad[$], ada[$];
   int frames = 0, errs = 0, err_lat = 0;
   int excl_bad = 0, hunt_bad = 0, fd_bad = 0, lat_bad = 0;
   bit stream_q[$];
   int exp_v[$], exp_a[$];
   int exp_frames = 0;

   always @(posedge CLK_40) cyc <= cyc + 1;
   always @(posedge SPI_clk) edge_cyc = cyc;

   // Observer: record every strobe and protocol-rule breach
   always @(negedge CLK_40) begin
      if (reset) begin
         if (bus.write_video) begin
            vad.push_back(int'(bus.wr_addr));
            vda.push_back(int'(bus.wr_data));
            if (cyc - edge_cyc != 4) lat_bad++;
         end
         if (bus.write_audio) begin
            aad.push_back(int'(bus.wr_addr));
            ada.push_back(int'(bus.wr_data));
            if (cyc - edge_cyc != 4) lat_bad++;
         end
         if (bus.write_video && bus.write_audio) excl_bad++;
         if ((bus.write_video || bus.write_audio) && !bus.in_packet) hunt_bad++;
         if (bus.frame_done) begin
            frames++;
            if (!bus.write_audio || int'(bus.wr_addr) != AB - 1) fd_bad++;
         end
         if (bus.err) begin
            errs++;
            err_lat = cyc - edge_cyc;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic push_bit(input bit b);
      stream_q.push_back(b);
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int j = 7; j >= 0; j--) stream_q.push_back(b[j]);
   endtask

   task automatic clear_obs();
      vad.delete(); vda.delete(); aad.delete(); ada.delete();
      frames = 0;
      errs   = 0;
   endtask

   // Reference: first run of eight ones is the header; following whole bytes fill video then audio.
   task automatic build_expect();
      int ones = 0;
      int start = -1;
      int nbytes;
      int b;
      exp_v.delete(); exp_a.delete();
      exp_frames = 0;
      foreach (stream_q[i]) begin
         if (start < 0) begin
            ones = stream_q[i] ? ones + 1 : 0;
            if (ones == 8) start = i + 1;
         end
      end
      if (start >= 0) begin
         nbytes = (stream_q.size() - start) / 8;
         if (nbytes > VB + AB) nbytes = VB + AB;
         for (int k = 0; k < nbytes; k++) begin
            b = 0;
            for (int j = 0; j < 8; j++) b = b * 2 + int'(stream_q[start + 8 * k + j]);
            if (k < VB) exp_v.push_back(b);
            else        exp_a.push_back(b);
         end
         if (nbytes == VB + AB) exp_frames = 1;
      end
   endtask

   task automatic send_stream();
      foreach (stream_q[i]) begin
         MISO = stream_q[i];
         #250;
         SPI_clk = 1'b1;
         #500;
         SPI_clk = 1'b0;
         #250;
      end
      MISO = 1'b0;
      repeat (10) @(posedge CLK_40);
      #1;
   endtask

   task automatic check_packet(input string tag, input bit expect_idle);
      chk({tag, "_vcnt"}, 32'(vad.size()), 32'(exp_v.size()));
      for (int k = 0; k < vad.size() && k < exp_v.size(); k++) begin
         chk({tag, "_vaddr"}, 32'(vad[k]), 32'(k));
         chk({tag, "_vdata"}, 32'(vda[k]), 32'(exp_v[k]));
      end
      chk({tag, "_acnt"}, 32'(aad.size()), 32'(exp_a.size()));
      for (int k = 0; k < aad.size() && k < exp_a.size(); k++) begin
         chk({tag, "_aaddr"}, 32'(aad[k]), 32'(k));
         chk({tag, "_adata"}, 32'(ada[k]), 32'(exp_a[k]));
      end
      chk({tag, "_frames"}, 32'(frames), 32'(exp_frames));
      if (expect_idle) chk({tag, "_inpkt"}, 32'(bus.in_packet), 32'h0);
   endtask

   task automatic random_packet(input string tag);
      stream_q.delete();
      repeat ($urandom_range(2, 6)) push_bit(1'b0);
      push_byte(8'hFF);
      repeat (VB + AB) push_byte(8'($urandom_range(0, 255)));
      clear_obs();
      build_expect();
      send_stream();
      check_packet(tag, 1'b1);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_data"},  32'(bus.wr_data),     32'h0);
      chk({tag, "_addr"},  32'(bus.wr_addr),     32'h0);
      chk({tag, "_wv"},    32'(bus.write_video), 32'h0);
      chk({tag, "_wa"},    32'(bus.write_audio), 32'h0);
      chk({tag, "_inpkt"}, 32'(bus.in_packet),   32'h0);
      chk({tag, "_fd"},    32'(bus.frame_done),  32'h0);
      chk({tag, "_err"},   32'(bus.err),         32'h0);
   endtask

   initial begin
      // Reset state
      #40;
      check_outputs_zero("reset");
      @(negedge CLK_40);
      reset = 1'b1;
      en    = 1'b1;
      repeat (3) @(posedge CLK_40);

      // Nominal packet with fixed content
      stream_q.delete();
      repeat (4) push_bit(1'b0);
      push_byte(8'hFF);
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
      push_byte(8'hAA); push_byte(8'h55);
      clear_obs();
      build_expect();
      send_stream();
      check_packet("nominal", 1'b1);
      if (vda.size() == VB && ada.size() == AB) begin
         chk("nom_v0", 32'(vda[0]), 32'h11);
         chk("nom_v3", 32'(vda[3]), 32'h44);
         chk("nom_a1", 32'(ada[1]), 32'h55);
      end else begin
         chk("nom_sizes", 32'(vda.size() * 16 + ada.size()), 32'(VB * 16 + AB));
      end

      // Randomised packets
      for (int p = 0; p < 4; p++) random_packet("random");

      // Misaligned header: 0 1111_1111 then payload whose first MSB is 0
      stream_q.delete();
      push_bit(1'b0);
      push_byte(8'hFF);
      push_byte(8'h3C);
      repeat (VB + AB - 1) push_byte(8'($urandom_range(0, 255)));
      clear_obs();
      build_expect();
      send_stream();
      check_packet("misalign", 1'b1);
      if (vda.size() > 0) chk("misalign_v0", 32'(vda[0]), 32'h3C);
      else                chk("misalign_any", 32'(vda.size()), 32'h1);

      // Header bytes inside the payload are plain data
      stream_q.delete();
      repeat (3) push_bit(1'b0);
      push_byte(8'hFF);
      push_byte(8'hFF); push_byte(8'hFF); push_byte(8'h00); push_byte(8'h01);
      push_byte(8'h7E); push_byte(8'h81);
      clear_obs();
      build_expect();
      send_stream();
      check_packet("hdr_in_payload", 1'b1);

      // Abort: en drops after two video bytes plus three bits
      stream_q.delete();
      repeat (3) push_bit(1'b0);
      push_byte(8'hFF);
      push_byte(8'h5A); push_byte(8'hC3);
      push_bit(1'b1); push_bit(1'b0); push_bit(1'b1);
      clear_obs();
      build_expect();
      send_stream();
      chk("abort_inpkt_before", 32'(bus.in_packet), 32'h1);
      @(negedge CLK_40);
      en = 1'b0;
      @(posedge CLK_40);
      #1;
      chk("abort_inpkt_after", 32'(bus.in_packet), 32'h0);
      repeat (5) @(posedge CLK_40);
      #1;
      check_packet("abort", 1'b1);
      chk("abort_vstrobes", 32'(vad.size()), 32'h2);
      @(negedge CLK_40);
      en = 1'b1;
      random_packet("after_abort");

      // Asynchronous reset in the middle of the audio section
      stream_q.delete();
      repeat (3) push_bit(1'b0);
      push_byte(8'hFF);
      push_byte(8'h12); push_byte(8'h34); push_byte(8'h56); push_byte(8'h78);
      push_byte(8'h5A);
      clear_obs();
      build_expect();
      send_stream();
      check_packet("pre_reset", 1'b0);
      chk("pre_reset_inpkt", 32'(bus.in_packet), 32'h1);
      #5;
      reset = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      repeat (3) @(posedge CLK_40);
      @(negedge CLK_40);
      reset = 1'b1;
      random_packet("after_reset");

      // SPI clock stalls in the middle of the video section
      stream_q.delete();
      repeat (3) push_bit(1'b0);
      push_byte(8'hFF);
      push_byte(8'hA5);
      push_bit(1'b0); push_bit(1'b1); push_bit(1'b1);
      clear_obs();
      build_expect();
      send_stream();
`ifdef SD_STREAM_TIMEOUT_EN
      for (int k = 0; k < 300 && errs == 0; k++) @(posedge CLK_40);
      #1;
      chk("tmo_err_seen", 32'(errs), 32'h1);
      chk("tmo_latency", 32'((err_lat >= 100) && (err_lat <= 106)), 32'h1);
      repeat (2) @(posedge CLK_40);
      #1;
      chk("tmo_inpkt", 32'(bus.in_packet), 32'h0);
      repeat (200) @(posedge CLK_40);
      #1;
      chk("tmo_err_once", 32'(errs), 32'h1);
      check_packet("timeout", 1'b1);
`else
      repeat (300) @(posedge CLK_40);
      #1;
      chk("stall_no_err", 32'(errs), 32'h0);
      chk("stall_waits", 32'(bus.in_packet), 32'h1);
      check_packet("stall", 1'b0);
      @(negedge CLK_40);
      en = 1'b0;
      repeat (3) @(posedge CLK_40);
      @(negedge CLK_40);
      en = 1'b1;
`endif
      random_packet("after_stall");

      // Protocol rules observed across the whole run
      chk("strobe_exclusive", 32'(excl_bad), 32'h0);
      chk("strobe_in_hunt",   32'(hunt_bad), 32'h0);
      chk("frame_done_align", 32'(fd_bad),   32'h0);
      chk("strobe_latency",   32'(lat_bad),  32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sd_stream_demux.md
Name: sd_stream_demux

Overview:
- Receives the raw SD-card byte stream and sits between the SPI pins (SPI_clk, MISO) and the video/audio buffer writers in badApple_top.
- Samples SPI_clk and MISO in the CLK_40 domain and deserialises MSB-first.
- Hunts for the 8'hFF packet header, then routes a fixed-length payload: VIDEO_BYTES to the video buffer, then AUDIO_BYTES to the audio buffer, with per-byte write strobes and addresses.

Parameters:
- HEADER, 8'hFF, packet header byte, matched bit-aligned.
- VIDEO_BYTES, 2400, video bytes per packet (160x120 at 1 bpp).
- AUDIO_BYTES, 128, audio bytes per packet.
- TIMEOUT_CYCLES, 4096, CLK_40 cycles without an SPI_clk rising edge before abort (optional feature only).

Ports:
- CLK_40  in  1  system clock, 40 MHz.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  stream enable from the SD init controller; high once card init is complete.
- SPI_clk  in  1  SPI clock, asynchronous to CLK_40, at most CLK_40/4.
- MISO  in  1  serial data, valid on SPI_clk rising edge.
- wr_data  out  8  payload byte.
- wr_addr  out  ADDR_W  byte index within the current section; ADDR_W = $clog2(max(VIDEO_BYTES, AUDIO_BYTES)).
- write_video  out  1  one-cycle strobe: wr_data/wr_addr target the video buffer.
- write_audio  out  1  one-cycle strobe: wr_data/wr_addr target the audio buffer.
- in_packet  out  1  high from header match until the last audio byte is written.
- frame_done  out  1  one-cycle pulse with the final audio strobe.
- err  out  1  one-cycle pulse on timeout abort; tied 0 when the feature is compiled out.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, synchronisers 0, state HUNT, counters 0.
- Input capture: SPI_clk and MISO each pass a 2-flop synchroniser.
- A bit event is one CLK_40 cycle where the synced SPI_clk is 1 and its previous sample was 0. MISO is taken from the same synced stage.
- Shift register: sh <= {sh[6:0], miso_s} on each bit event.
- State HUNT (in_packet=0):
  - Shift on every bit event while en=1.
  - When the updated sh == HEADER: go to VIDEO, clear the bit counter (3 b) and byte counter, and set in_packet the next cycle.
  - Bit events while en=0 are ignored; sh holds its value.
- State VIDEO:
  - Each 8th bit event completes a byte.
  - The cycle after completion: write_video=1, wr_data=byte, wr_addr=byte count, then the count increments.
  - After byte VIDEO_BYTES-1 is written: go to AUDIO with the count at 0.
- State AUDIO:
  - Same as VIDEO, using write_audio.
  - On byte AUDIO_BYTES-1: frame_done=1 in the same cycle as the strobe, then HUNT with in_packet=0 and sh cleared to 0. A stale 0xFF cannot re-trigger.
- Latency: the write strobe asserts exactly 4 CLK_40 cycles after the raw SPI_clk rising edge carrying bit 0 of the byte (2 sync + 1 edge + 1 register).
- Strobes:
  - write_video and write_audio are never high together and are never high in HUNT.
  - wr_data/wr_addr hold their last value when no strobe is active.
- en falling in VIDEO/AUDIO: abort to HUNT on the next cycle. No strobe for a partial byte, no frame_done, counters and sh cleared.
- Byte complete in the same cycle en falls: the byte is dropped (abort has priority).
- The address restarts at 0 for each section of each packet; it never wraps within a section.
- Payload bytes equal to HEADER are plain data; no resync inside a packet.

Optional Feature:
- Macro: SD_STREAM_TIMEOUT_EN.
- Defined: a counter resets on every bit event and counts CLK_40 cycles in VIDEO/AUDIO. On reaching TIMEOUT_CYCLES: err pulses for 1 cycle, then the same abort as en falling.
- Undefined: no counter; err is constant 0; the block waits indefinitely.

Decomposition:
- Shared package stream_pkg holds:
  - state enum {HUNT, VIDEO, AUDIO}.
  - HEADER constant.
  - Default VIDEO_BYTES, AUDIO_BYTES and TIMEOUT_CYCLES.
- One sub-module, spi_bit_sampler: the 2-flop synchronisers plus rising-edge detect, producing bit_valid and bit_data. The demux FSM stays in the top module.

Test Plan:
(Bench parameters: VIDEO_BYTES=4, AUDIO_BYTES=2, SPI_clk 1 MHz.)
- Nominal packet: en=1, MISO idle 0, send FF, then 11 22 33 44 and AA 55.
  - write_video with addr 0..3, data 11,22,33,44.
  - write_audio with addr 0..1, data AA,55.
  - frame_done on the AA..55 last strobe; in_packet low afterwards.
- Misaligned header: send bits 0 1 1 1 1 1 1 1 1 0 and then a packet.
  - Header is found at bit offset 1 and the first video byte is correct.
- Header inside payload: video bytes FF FF 00 01.
  - All 4 are written as data; no restart of addressing.
- Abort: drop en after 2 video bytes plus 3 bits.
  - Exactly 2 write_video strobes; in_packet=0 within 1 cycle.
  - A following full packet is received correctly.
- Async reset mid-AUDIO: reset=0 for 3 cycles.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, the next FF packet decodes from addr 0.
- With SD_STREAM_TIMEOUT_EN and TIMEOUT_CYCLES=100: stop SPI_clk mid-video.
  - err pulses once 100 cycles after the last edge; state returns to HUNT.
